setup_reg_bank: RTL and testbench



---
 rtl/setup_pkg.sv | 23 ++
 rtl/setup_frame_rx.sv | 91 +++++++++
 rtl/setup_reg_bank.sv | 71 +++++++
 tb/tb_setup_reg_bank.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/setup_pkg.sv
// Shared types and sizing helpers for the serial setup register bank.
// Pure declarations; no latency and no backpressure.
package setup_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_NUM_REGS = 4;

    // A single-word bank still carries one address bit so the frame format stays uniform.
    function automatic int addr_w(input int num_regs);
        return (num_regs <= 1) ? 1 : $clog2(num_regs);
    endfunction

    function automatic int frame_len(input int width, input int num_regs);
        return addr_w(num_regs) + width;
    endfunction

endpackage

// File: rtl/setup_frame_rx.sv
// Serial frame receiver: collects address+data bits, reports frame_valid/abort combinationally
// on the sampling edge of the last bit / the en drop; no backpressure, serial line is never stalled.
module setup_frame_rx
    import setup_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter bit MSB_FIRST = 1'b0,
    localparam int ADDR_W    = addr_w(NUM_REGS),
    localparam int FRAME_LEN = frame_len(WIDTH, NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              serial,
    output logic              frame_valid,
    output logic              abort,
    output logic [ADDR_W-1:0] addr,
    output logic [WIDTH-1:0]  data
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    state_t                 state;
    logic [CNT_W-1:0]       count;
    logic [FRAME_LEN-2:0]   sr;
    logic [FRAME_LEN-1:0]   full;
    logic                   last;

    // full[i] is the i-th bit received; the final bit is taken straight from the line
    // so the bank can commit on the very edge that samples it.
    assign full = {serial, sr};
    assign last = (count == CNT_W'(FRAME_LEN - 1));

    assign frame_valid = (state == SHIFT) && en && last;
    assign abort       = (state == SHIFT) && !en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            sr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        sr    <= full[FRAME_LEN-1:1];
                        count <= CNT_W'(1);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!en) begin
                        count <= '0;
                        state <= IDLE;
                    end else if (last) begin
                        count <= '0;
                        state <= HOLD;
                    end else begin
                        sr    <= full[FRAME_LEN-1:1];
                        count <= count + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (!en) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    count <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    generate
        if (MSB_FIRST) begin : g_msb
            for (genvar i = 0; i < ADDR_W; i++) begin : g_addr
                assign addr[i] = full[ADDR_W-1-i];
            end
            for (genvar j = 0; j < WIDTH; j++) begin : g_data
                assign data[j] = full[FRAME_LEN-1-j];
            end
        end else begin : g_lsb
            assign addr = full[ADDR_W-1:0];
            assign data = full[FRAME_LEN-1:ADDR_W];
        end
    endgenerate

endmodule

// File: rtl/setup_reg_bank.sv
// Bank of NUM_REGS configuration words loaded by addressed serial frames; word visible and
// done/err registered on the last-bit edge; no backpressure, out-of-range frames are dropped with err.
module setup_reg_bank
    import setup_pkg::*;
#(
    parameter int               WIDTH       = DEF_WIDTH,
    parameter int               NUM_REGS    = DEF_NUM_REGS,
    parameter bit               MSB_FIRST   = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      en_in,
    input  logic                      serial_in,
    output logic [NUM_REGS*WIDTH-1:0] parallel_out,
    output logic                      done_out,
    output logic                      err_out
);

    localparam int ADDR_W = addr_w(NUM_REGS);

    logic              frame_valid;
    logic              abort;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
    logic              in_range;
    logic [WIDTH-1:0]  bank [NUM_REGS];

    setup_frame_rx #(
        .WIDTH     (WIDTH),
        .NUM_REGS  (NUM_REGS),
        .MSB_FIRST (MSB_FIRST)
    ) u_rx (
        .clk         (clk_in),
        .rst         (rst_in),
        .en          (en_in),
        .serial      (serial_in),
        .frame_valid (frame_valid),
        .abort       (abort),
        .addr        (addr),
        .data        (data)
    );

    // Non-power-of-two banks leave address codes with no backing word.
    assign in_range = (int'(addr) < NUM_REGS);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                bank[k] <= RESET_VALUE;
            end
            done_out <= 1'b0;
            err_out  <= 1'b0;
        end else begin
            done_out <= frame_valid && in_range;
            err_out  <= abort || (frame_valid && !in_range);
            for (int k = 0; k < NUM_REGS; k++) begin
                if (frame_valid && in_range && (int'(addr) == k)) begin
                    bank[k] <= data;
                end
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_REGS; k++) begin : g_pack
            assign parallel_out[k*WIDTH +: WIDTH] = bank[k];
        end
    endgenerate

endmodule

// File: tb/tb_setup_reg_bank.sv
// Directed bench for setup_reg_bank: three configurations (default, 3-word bank, MSB-first 16-bit).
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
module tb_setup_reg_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, ser_a, en_b, ser_b, en_c, ser_c;
    logic [31:0] par_a;
    logic [23:0] par_b;
    logic [31:0] par_c;
    logic        done_a, err_a, done_b, err_b, done_c, err_c;

    int checks = 0;
    int errors = 0;
    int nd_a, ne_a, nd_b, ne_b, nd_c, ne_c, both;

    always #5 clk = ~clk;

    setup_reg_bank #(.WIDTH(8), .NUM_REGS(4), .MSB_FIRST(1'b0), .RESET_VALUE(8'h00)) dut_a (
        .clk_in(clk), .rst_in(rst), .en_in(en_a), .serial_in(ser_a),
        .parallel_out(par_a), .done_out(done_a), .err_out(err_a));

    setup_reg_bank #(.WIDTH(8), .NUM_REGS(3), .MSB_FIRST(1'b0), .RESET_VALUE(8'h00)) dut_b (
        .clk_in(clk), .rst_in(rst), .en_in(en_b), .serial_in(ser_b),
        .parallel_out(par_b), .done_out(done_b), .err_out(err_b));

    setup_reg_bank #(.WIDTH(16), .NUM_REGS(2), .MSB_FIRST(1'b1), .RESET_VALUE(16'h1234)) dut_c (
        .clk_in(clk), .rst_in(rst), .en_in(en_c), .serial_in(ser_c),
        .parallel_out(par_c), .done_out(done_c), .err_out(err_c));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr_counts();
        nd_a = 0; ne_a = 0; nd_b = 0; ne_b = 0; nd_c = 0; ne_c = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        nd_a += int'(done_a); ne_a += int'(err_a);
        nd_b += int'(done_b); ne_b += int'(err_b);
        nd_c += int'(done_c); ne_c += int'(err_c);
        both += int'(done_a & err_a) + int'(done_b & err_b) + int'(done_c & err_c);
    endtask

    // vec[i] is the i-th bit on the line: {data, addr}, LSB first within each field.
    task automatic send10(input int which, input logic [9:0] vec, input int from, input int to);
        for (int i = from; i <= to; i++) begin
            if (which == 0) begin en_a = 1'b1; ser_a = vec[i]; end
            else            begin en_b = 1'b1; ser_b = vec[i]; end
            tick();
        end
    endtask

    task automatic idle(input int n);
        en_a = 1'b0; ser_a = 1'b0;
        en_b = 1'b0; ser_b = 1'b0;
        en_c = 1'b0; ser_c = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
    endtask

    initial begin
        logic [16:0] cvec;
        both = 0;
        clr_counts();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);

        // Reset state
        chk("reset_par_a", 64'(par_a), 64'h0);
        chk("reset_par_b", 64'(par_b), 64'h0);
        chk("reset_par_c", 64'(par_c), 64'h12341234);
        chk("reset_flags_a", 64'({done_a, err_a}), 64'h0);

        // Test 1: addr 2, data 0xAA, then 6 extra 1-bits
        clr_counts();
        send10(0, {8'hAA, 2'd2}, 0, 8);
        chk("t1_no_done_at_9", 64'(done_a), 64'h0);
        chk("t1_par_before_commit", 64'(par_a), 64'h0);
        send10(0, {8'hAA, 2'd2}, 9, 9);
        chk("t1_done_at_10", 64'(done_a), 64'h1);
        chk("t1_par_commit", 64'(par_a), 64'h00AA0000);
        send10(0, 10'h3FF, 0, 5);
        chk("t1_par_after_extra", 64'(par_a), 64'h00AA0000);
        chk("t1_done_count", 64'(nd_a), 64'd1);
        chk("t1_err_count", 64'(ne_a), 64'd0);
        idle(1);

        // Test 2: two back-to-back writes with one idle cycle
        pulse_reset();
        clr_counts();
        send10(0, {8'h12, 2'd0}, 0, 9);
        idle(1);
        send10(0, {8'hCD, 2'd3}, 0, 9);
        idle(1);
        chk("t2_par", 64'(par_a), 64'hCD000012);
        chk("t2_done_count", 64'(nd_a), 64'd2);
        chk("t2_err_count", 64'(ne_a), 64'd0);

        // Test 3: abort after 5 bits, then a full frame to addr 1
        clr_counts();
        send10(0, {8'h3C, 2'd1}, 0, 4);
        en_a = 1'b0; ser_a = 1'b0;
        tick();
        chk("t3_abort_err", 64'(err_a), 64'h1);
        chk("t3_abort_no_done", 64'(done_a), 64'h0);
        tick();
        chk("t3_err_one_cycle", 64'(err_a), 64'h0);
        chk("t3_par_unchanged", 64'(par_a), 64'hCD000012);
        send10(0, {8'hFF, 2'd1}, 0, 9);
        chk("t3_retry_done", 64'(done_a), 64'h1);
        idle(1);
        chk("t3_par_retry", 64'(par_a), 64'hCD00FF12);
        chk("t3_counts", 64'({nd_a[7:0], ne_a[7:0]}), 64'h0101);

        // Test 4: 3-word bank, out-of-range address 3
        send10(1, {8'h11, 2'd1}, 0, 9);
        idle(1);
        chk("t4_par_setup", 64'(par_b), 64'h001100);
        clr_counts();
        send10(1, {8'h55, 2'd3}, 0, 9);
        chk("t4_bad_addr_err", 64'(err_b), 64'h1);
        chk("t4_bad_addr_no_done", 64'(done_b), 64'h0);
        idle(1);
        chk("t4_par_unchanged", 64'(par_b), 64'h001100);
        chk("t4_counts", 64'({nd_b[7:0], ne_b[7:0]}), 64'h0001);

        // Test 5: asynchronous reset mid-frame after 7 bits
        send10(0, {8'h77, 2'd3}, 0, 6);
        #2;
        rst = 1'b1;
        en_a = 1'b0; ser_a = 1'b0;
        #1;
        chk("t5_async_par_a", 64'(par_a), 64'h0);
        chk("t5_async_par_c", 64'(par_c), 64'h12341234);
        chk("t5_async_flags", 64'({done_a, err_a}), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        clr_counts();
        send10(0, {8'h5A, 2'd0}, 0, 8);
        chk("t5_no_early_done", 64'(done_a), 64'h0);
        send10(0, {8'h5A, 2'd0}, 9, 9);
        chk("t5_done", 64'(done_a), 64'h1);
        chk("t5_par", 64'(par_a), 64'h0000005A);
        idle(1);

        // Test 6: MSB first, 16-bit words, addr 1 <- 0xBEEF
        clr_counts();
        cvec = {1'b1, 16'hBEEF};
        for (int i = 16; i >= 0; i--) begin
            en_c = 1'b1; ser_c = cvec[i];
            tick();
        end
        chk("t6_done", 64'(done_c), 64'h1);
        chk("t6_par", 64'(par_c), 64'hBEEF1234);
        idle(2);
        chk("t6_counts", 64'({nd_c[7:0], ne_c[7:0]}), 64'h0100);

        chk("never_done_and_err", 64'(both), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
